// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and helpers for the memory responder.
// Holds the responder FSM state encoding, the legal byte-enable patterns
// and the alignment classifier used when MEM_RESP_ALIGN_CHECK_EN is defined.
package mem_resp_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of the latency down-counter; LATENCY is limited to 1..15.
  localparam int CNT_W = 4;

  // Multi-byte enable patterns produced by the store-size logic.
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // True when the byte enables agree with the low address bits:
  // words at offset 0, halfwords at offset 0 or 2, bytes at their own lane.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addrLo);
    logic ok;
    ok = 1'b0;
    case (be)
      BE_WORD:    ok = (addrLo == 2'd0);
      BE_HALF_LO: ok = (addrLo == 2'd0);
      BE_HALF_HI: ok = (addrLo == 2'd2);
      4'b0001:    ok = (addrLo == 2'd0);
      4'b0010:    ok = (addrLo == 2'd1);
      4'b0100:    ok = (addrLo == 2'd2);
      4'b1000:    ok = (addrLo == 2'd3);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU datapath and the
// memory responder.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. Once valid is raised, the source holds
// valid and its payload stable until that edge. ready never depends
// combinationally on valid. The request channel is req_*, sourced by the
// master; the response channel is resp_*, sourced by the slave, with
// resp_ready driven by the master.
interface mem_responder_if #(
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Datapath side.
  modport master (
    output req_valid, req_addr, req_write, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory responder side.
  modport slave (
    input  req_valid, req_addr, req_write, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_resp_bank.sv
// mem_resp_bank: word-organised RAM built from four byte-lane arrays.
// Each lane has its own write enable. The 32-bit read port is registered
// and loads on every access; for a written lane it returns the new byte so
// a store response carries the word contents after the write. clr forces
// the captured word to zero without touching the arrays. Only the read
// register is reset; the arrays keep their contents across reset.
module mem_resp_bank #(
  parameter int WORD_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc,
  input  logic               clr,
  input  logic [3:0]         we,
  input  logic [WORD_AW-1:0] wordIdx,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int WORDS = 1 << WORD_AW;

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] laneQ;
    logic [7:0] laneWdata;

    assign laneWdata = wdata[8*lane +: 8];

    // Byte-lane array write; no reset so contents survive a CPU reset.
    always_ff @(posedge clk) begin
      if (acc && we[lane]) begin
        mem[wordIdx] <= laneWdata;
      end
    end

    // Registered lane read with write-through of the byte being stored.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        laneQ <= 8'h00;
      end else if (acc) begin
        if (clr) begin
          laneQ <= 8'h00;
        end else if (we[lane]) begin
          laneQ <= laneWdata;
        end else begin
          laneQ <= mem[wordIdx];
        end
      end
    end

    assign rdata[8*lane +: 8] = laneQ;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU load/store
// path. Accepts one request at a time, waits LATENCY cycles, performs the
// access on mem_resp_bank and holds the response until it is taken.
//
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN. When defined, each
// request's (req_be, req_addr[1:0]) pair is classified at accept; illegal
// pairs skip the RAM write, return a zero word and raise resp_err. When
// undefined, req_addr[1:0] is ignored and resp_err is tied low.
//
// Timing: a request accepted at edge T always passes through WAIT with the
// counter loaded to LATENCY-1, so the access (and the RAM write) lands on
// edge T+LATENCY and resp_valid rises after that same edge, including the
// LATENCY == 1 case where WAIT lasts exactly one cycle.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output state_t          dbgState
);

  localparam int              WORD_AW  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t             state;
  state_t             stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cntNext;

  // Latched request.
  logic [WORD_AW-1:0] wordQ;
  logic               writeQ;
  logic [3:0]         beQ;
  logic [31:0]        wdataQ;
  logic               errQ;

  logic               accept;
  logic               access;
  logic               reqErr;
  logic [3:0]         bankWe;
  logic [31:0]        bankRdata;

  assign accept = (state == IDLE) && bus.req_valid;
  assign access = (state == WAIT) && (cnt == '0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign reqErr = !be_legal(bus.req_be, bus.req_addr[1:0]);
`else
  // Low address bits select nothing when alignment is not checked.
  logic unusedAddrLo;
  assign unusedAddrLo = ^bus.req_addr[1:0];
  assign reqErr       = 1'b0;
`endif

  // FSM state and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          stateNext = WAIT;
          cntNext   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          stateNext = RESP;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Capture the request payload and its alignment verdict on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wordQ  <= '0;
      writeQ <= 1'b0;
      beQ    <= 4'h0;
      wdataQ <= 32'h0;
      errQ   <= 1'b0;
    end else if (accept) begin
      wordQ  <= bus.req_addr[ADDR_W-1:2];
      writeQ <= bus.req_write;
      beQ    <= bus.req_be;
      wdataQ <= bus.req_wdata;
      errQ   <= reqErr;
    end
  end

  // Loads and rejected requests never write; byte enables only gate stores.
  assign bankWe = (writeQ && !errQ) ? beQ : 4'h0;

  mem_resp_bank #(
    .WORD_AW (WORD_AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .acc     (access),
    .clr     (errQ),
    .we      (bankWe),
    .wordIdx (wordQ),
    .wdata   (wdataQ),
    .rdata   (bankRdata)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = bankRdata;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign bus.resp_err = (state == RESP) && errQ;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign dbgState = state;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. Three instances run
// side by side (LATENCY 2, 1 and 4) sharing clock and reset; expectations
// follow MEM_RESP_ALIGN_CHECK_EN when the bench is built with it.
module tb_mem_responder;
  import mem_resp_pkg::*;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  mem_responder_if #(.ADDR_W(8)) b2 ();
  mem_responder_if #(.ADDR_W(8)) b1 ();
  mem_responder_if #(.ADDR_W(8)) b4 ();
  state_t st2, st1, st4;

  mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(b2), .dbgState(st2));
  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .dbgState(st1));
  mem_responder #(.ADDR_W(8), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4), .dbgState(st4));

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int which, input logic v, input logic [7:0] a,
                           input logic w, input logic [3:0] be, input logic [31:0] d);
    case (which)
      1: begin b1.req_valid = v; b1.req_addr = a; b1.req_write = w; b1.req_be = be; b1.req_wdata = d; end
      4: begin b4.req_valid = v; b4.req_addr = a; b4.req_write = w; b4.req_be = be; b4.req_wdata = d; end
      default: begin b2.req_valid = v; b2.req_addr = a; b2.req_write = w; b2.req_be = be; b2.req_wdata = d; end
    endcase
  endtask

  task automatic set_resp_ready(input int which, input logic r);
    case (which)
      1: b1.resp_ready = r;
      4: b4.resp_ready = r;
      default: b2.resp_ready = r;
    endcase
  endtask

  task automatic sample(input int which, output logic rv, output logic rq,
                        output logic [31:0] rd, output logic er);
    case (which)
      1: begin rv = b1.resp_valid; rq = b1.req_ready; rd = b1.resp_rdata; er = b1.resp_err; end
      4: begin rv = b4.resp_valid; rq = b4.req_ready; rd = b4.resp_rdata; er = b4.resp_err; end
      default: begin rv = b2.resp_valid; rq = b2.req_ready; rd = b2.resp_rdata; er = b2.resp_err; end
    endcase
  endtask

  // One full request/response; lat = edges from accept to resp_valid, -1 on timeout.
  // Called and returns at 1 time unit after a rising edge.
  task automatic transact(input int which, input logic w, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
    logic rv, rq, ter;
    logic [31:0] trd;
    int budget;
    budget = 0;
    sample(which, rv, rq, trd, ter);
    while (!rq && budget < 50) begin
      @(posedge clk); #1;
      budget++;
      sample(which, rv, rq, trd, ter);
    end
    drive_req(which, 1'b1, a, w, be, d);
    @(posedge clk); #1;
    drive_req(which, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    lat = 0;
    rv = 1'b0;
    while (!rv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(which, rv, rq, trd, ter);
    end
    if (!rv) lat = -1;
    rd = trd;
    er = ter;
    set_resp_ready(which, 1'b1);
    @(posedge clk); #1;
    set_resp_ready(which, 1'b0);
  endtask

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [32];

  // ---------------- tests ----------------
  task automatic test_reset();
    logic rv, rq, er;
    logic [31:0] rd;
    reset = 1'b0;
    drive_req(2, 1'b1, 8'd8, 1'b1, 4'hF, 32'h12345678);
    repeat (3) @(posedge clk);
    #1;
    sample(2, rv, rq, rd, er);
    tests_run++; if (rv !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b expected 0", rv); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_rdata: got %h expected 00000000", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err: got %b expected 0", er); end
    tests_run++; if (rq !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 1", rq); end
    tests_run++; if (st2 !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", st2, IDLE); end
    drive_req(2, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (st2 !== IDLE) begin tests_failed++; $display("FAIL reset_release_state: got %0d expected %0d", st2, IDLE); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    transact(2, 1'b1, 8'd8, 4'hF, 32'hDEADBEEF, rd, er, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL store_latency: got %0d expected 2", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL store_rdata: got %h expected deadbeef", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL store_err: got %b expected 0", er); end
    transact(2, 1'b0, 8'd8, 4'hF, 32'h0, rd, er, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL load_latency: got %0d expected 2", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er; int lat;
    transact(2, 1'b1, 8'd9, 4'b0010, 32'h0000AA00, rd, er, lat);
    tests_run++; if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL byte_store_rdata: got %h expected deadaaef", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL byte_store_err: got %b expected 0", er); end
    transact(2, 1'b0, 8'd8, 4'hF, 32'h0, rd, er, lat);
    tests_run++; if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL byte_load_rdata: got %h expected deadaaef", rd); end
  endtask

  task automatic test_backpressure();
    logic rv, rq, er;
    logic [31:0] rd;
    int n;
    int lat;
    drive_req(2, 1'b1, 8'd8, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    // A competing store is held on the bus for the whole RESP stall.
    drive_req(2, 1'b1, 8'd8, 1'b1, 4'hF, 32'h0BADF00D);
    n = 0;
    sample(2, rv, rq, rd, er);
    while (!rv && n < 20) begin
      @(posedge clk); #1;
      n++;
      sample(2, rv, rq, rd, er);
    end
    tests_run++; if (rv !== 1'b1) begin tests_failed++; $display("FAIL bp_resp_arrives: got %b expected 1", rv); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sample(2, rv, rq, rd, er);
      tests_run++; if (rv !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, rv); end
      tests_run++; if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL bp_rdata_hold[%0d]: got %h expected deadaaef", i, rd); end
      tests_run++; if (rq !== 1'b0) begin tests_failed++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, rq); end
      tests_run++; if (st2 !== RESP) begin tests_failed++; $display("FAIL bp_state[%0d]: got %0d expected %0d", i, st2, RESP); end
    end
    drive_req(2, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    set_resp_ready(2, 1'b1);
    @(posedge clk); #1;
    set_resp_ready(2, 1'b0);
    sample(2, rv, rq, rd, er);
    tests_run++; if (rq !== 1'b1) begin tests_failed++; $display("FAIL bp_release_req_ready: got %b expected 1", rq); end
    tests_run++; if (rv !== 1'b0) begin tests_failed++; $display("FAIL bp_release_resp_valid: got %b expected 0", rv); end
    @(posedge clk); #1;
    tests_run++; if (st2 !== IDLE) begin tests_failed++; $display("FAIL bp_idle_after: got %0d expected %0d", st2, IDLE); end
    // The stalled store must not have reached memory.
    transact(2, 1'b0, 8'd8, 4'hF, 32'h0, rd, er, lat);
    tests_run++; if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL bp_no_write: got %h expected deadaaef", rd); end
  endtask

  task automatic test_latency1();
    logic [31:0] rd; logic er; int lat;
    transact(1, 1'b1, 8'd4, 4'hF, 32'h12345678, rd, er, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL lat1_store_latency: got %0d expected 1", lat); end
    tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL lat1_store_rdata: got %h expected 12345678", rd); end
    transact(1, 1'b0, 8'd4, 4'hF, 32'h0, rd, er, lat);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL lat1_load_latency: got %0d expected 1", lat); end
    tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL lat1_load_rdata: got %h expected 12345678", rd); end
  endtask

  task automatic test_reset_wait();
    logic rv, rq, er;
    logic [31:0] rd;
    int lat;
    transact(4, 1'b1, 8'd0, 4'hF, 32'hCAFEF00D, rd, er, lat);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL lat4_store_latency: got %0d expected 4", lat); end
    tests_run++; if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL lat4_store_rdata: got %h expected cafef00d", rd); end
    drive_req(4, 1'b1, 8'd0, 1'b1, 4'hF, 32'h11111111);
    @(posedge clk); #1;
    drive_req(4, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    tests_run++; if (st4 !== WAIT) begin tests_failed++; $display("FAIL lat4_in_wait: got %0d expected %0d", st4, WAIT); end
    reset = 1'b0;
    #1;
    sample(4, rv, rq, rd, er);
    tests_run++; if (rv !== 1'b0) begin tests_failed++; $display("FAIL rstwait_resp_valid: got %b expected 0", rv); end
    tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL rstwait_resp_rdata: got %h expected 00000000", rd); end
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL rstwait_resp_err: got %b expected 0", er); end
    tests_run++; if (st4 !== IDLE) begin tests_failed++; $display("FAIL rstwait_state: got %0d expected %0d", st4, IDLE); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    transact(4, 1'b0, 8'd0, 4'hF, 32'h0, rd, er, lat);
    tests_run++; if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL rstwait_old_word: got %h expected cafef00d", rd); end
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL rstwait_load_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_w;
    // Full word at offset 2: illegal when checked, otherwise lands on word 2.
    transact(2, 1'b1, 8'd10, 4'hF, 32'h55555555, rd, er, lat);
    exp_w = ALIGN ? 32'h0 : 32'h55555555;
    tests_run++; if (er !== ALIGN) begin tests_failed++; $display("FAIL align_word_err: got %b expected %b", er, ALIGN); end
    tests_run++; if (rd !== exp_w) begin tests_failed++; $display("FAIL align_word_rdata: got %h expected %h", rd, exp_w); end
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL align_word_latency: got %0d expected 2", lat); end
    transact(2, 1'b0, 8'd8, 4'hF, 32'h0, rd, er, lat);
    exp_w = ALIGN ? 32'hDEADAAEF : 32'h55555555;
    tests_run++; if (rd !== exp_w) begin tests_failed++; $display("FAIL align_mem_after: got %h expected %h", rd, exp_w); end
    transact(2, 1'b1, 8'd10, 4'b1100, 32'h77660000, rd, er, lat);
    exp_w = ALIGN ? 32'h7766AAEF : 32'h77665555;
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL align_half_hi_err: got %b expected 0", er); end
    tests_run++; if (rd !== exp_w) begin tests_failed++; $display("FAIL align_half_hi_rdata: got %h expected %h", rd, exp_w); end
    transact(2, 1'b0, 8'd9, 4'hF, 32'h0, rd, er, lat);
    exp_w = ALIGN ? 32'h0 : 32'h77665555;
    tests_run++; if (er !== ALIGN) begin tests_failed++; $display("FAIL align_load_err: got %b expected %b", er, ALIGN); end
    tests_run++; if (rd !== exp_w) begin tests_failed++; $display("FAIL align_load_rdata: got %h expected %h", rd, exp_w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, d, expw;
    logic er, w;
    logic [3:0] be;
    logic [1:0] off;
    int lat, widx, sel, n_resp, n_issued;
    n_resp = 0;
    n_issued = 0;
    for (int k = 0; k < 28; k++) begin
      if (k < 8) begin
        widx = k; w = 1'b1; be = 4'hF; off = 2'd0;
      end else begin
        widx = $urandom_range(0, 7);
        w = 1'($urandom_range(0, 1));
        be = 4'hF; off = 2'd0;
        if (w) begin
          sel = $urandom_range(0, 6);
          case (sel)
            0: begin be = 4'b1111; off = 2'd0; end
            1: begin be = 4'b0011; off = 2'd0; end
            2: begin be = 4'b1100; off = 2'd2; end
            default: begin be = 4'(1 << (sel - 3)); off = 2'(sel - 3); end
          endcase
        end
      end
      d = $urandom;
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[widx*4 + i] = d[8*i +: 8];
      end
      expw = {ref_mem[widx*4 + 3], ref_mem[widx*4 + 2], ref_mem[widx*4 + 1], ref_mem[widx*4]};
      exp_q.push_back(expw);
      n_issued++;
      transact(2, w, 8'(widx*4 + int'(off)), be, d, rd, er, lat);
      if (lat >= 0) begin
        n_resp++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL b2b_unexpected[%0d]: got %h with nothing expected", k, rd);
        end else begin
          expw = exp_q.pop_front();
          if (rd !== expw) begin tests_failed++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, rd, expw); end
        end
        tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL b2b_err[%0d]: got %b expected 0", k, er); end
      end
    end
    tests_run++; if (n_resp !== n_issued) begin tests_failed++; $display("FAIL b2b_count: got %0d expected %0d", n_resp, n_issued); end
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL b2b_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    drive_req(1, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    drive_req(2, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    drive_req(4, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0);
    set_resp_ready(1, 1'b0);
    set_resp_ready(2, 1'b0);
    set_resp_ready(4, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_byte_store();
    test_backpressure();
    test_latency1();
    test_reset_wait();
    test_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog timeout");
  end

endmodule
